// File: rtl/counter_param.sv
// counter_param: parametrised up/down counter/timer with load, wrap/saturate, tc pulse, sticky ovf.
// Latency: value, tc and ovf are registered and update one clk after the sampling edge.
// Backpressure: none; a new command is accepted on every edge (reset > load > en).
//
// Ports:
//   clk       rising-edge clock for all state
//   reset     synchronous active-low reset (value=0, tc=0, ovf=0)
//   en        count enable, one step per edge
//   up        direction, 1 = increment, 0 = decrement (used only when en=1)
//   load      parallel load strobe; load_val is clamped to MOD_MAX
//   load_val  value to load
//   clr_ovf   clears ovf unless a boundary event happens on the same edge
//   value     registered count, range 0..MOD_MAX
//   tc        registered pulse, high in the cycle value shows a post-boundary result
//   ovf       sticky flag, set by every boundary event (wrap or saturate)
module counter_param #(
  parameter int WIDTH    = 8,
  parameter int MOD_MAX  = 255,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] value_nxt;
  logic             boundary;
  logic             ovf_nxt;

  always_comb begin
    value_nxt = value;
    boundary  = 1'b0;
    if (load) begin
      // Clamp so value never leaves 0..MOD_MAX, even when MOD_MAX < 2**WIDTH-1.
      value_nxt = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (up) begin
        if (value >= MAX_V) begin
          // Explicit compare: wrap point is MOD_MAX, not the natural WIDTH rollover.
          boundary  = 1'b1;
          value_nxt = SATURATE ? MAX_V : '0;
        end else begin
          value_nxt = value + ONE_V;
        end
      end else begin
        if (value == '0) begin
          boundary  = 1'b1;
          value_nxt = SATURATE ? '0 : MAX_V;
        end else begin
          value_nxt = value - ONE_V;
        end
      end
    end

    // Set beats clear when both happen on the same edge.
    ovf_nxt = ovf;
    if (boundary) begin
      ovf_nxt = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      value <= value_nxt;
      tc    <= boundary;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: three configurations (8/255 wrap, 4/9 wrap, 4/9 saturate)
// share one input bundle; each directed step queues its expected result and a
// negedge monitor pops and compares it against the selected instance.
module tb_counter_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic       clr_ovf;

  logic [7:0] value_a;
  logic       tc_a, ovf_a;
  logic [3:0] value_b, value_c;
  logic       tc_b, ovf_b, tc_c, ovf_c;

  counter_param #(.WIDTH(8), .MOD_MAX(255), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .value(value_a), .tc(tc_a), .ovf(ovf_a)
  );

  counter_param #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[3:0]), .clr_ovf(clr_ovf),
    .value(value_b), .tc(tc_b), .ovf(ovf_b)
  );

  counter_param #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[3:0]), .clr_ovf(clr_ovf),
    .value(value_c), .tc(tc_c), .ovf(ovf_c)
  );

  typedef struct {
    int         sel;
    logic [7:0] v;
    logic       tc;
    logic       ovf;
    int         due;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   next_id   = 0;
  int   checks    = 0;
  int   errors    = 0;
  bit   finishing = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expectation falls due per cycle; compare it at the negedge.
  always @(negedge clk) begin
    logic [7:0] got_v;
    logic       got_tc, got_ovf;
    exp_t       e;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      case (e.sel)
        0:       begin got_v = value_a;         got_tc = tc_a; got_ovf = ovf_a; end
        1:       begin got_v = {4'h0, value_b}; got_tc = tc_b; got_ovf = ovf_b; end
        default: begin got_v = {4'h0, value_c}; got_tc = tc_c; got_ovf = ovf_c; end
      endcase
      checks++;
      if (got_v !== e.v || got_tc !== e.tc || got_ovf !== e.ovf || e.due != cyc) begin
        errors++;
        $display("FAIL step%0d dut%0d: got value=%0d tc=%b ovf=%b, expected value=%0d tc=%b ovf=%b",
                 e.id, e.sel, got_v, got_tc, got_ovf, e.v, e.tc, e.ovf);
      end
    end else if (finishing) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
    end
  end

  task automatic step(input int sel, input logic r, input logic e, input logic u,
                      input logic l, input logic [7:0] lv, input logic c,
                      input logic [7:0] ev, input logic et, input logic eo);
    exp_t x;
    @(posedge clk);
    #1;
    reset    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    clr_ovf  = c;
    x.sel = sel; x.v = ev; x.tc = et; x.ovf = eo; x.due = cyc + 1; x.id = next_id;
    next_id++;
    exp_q.push_back(x);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00; clr_ovf = 1'b0;

    // ---- dut_a: 8-bit, MOD_MAX=255, wrap ----
    step(0, 0, 1, 1, 0, 8'd0, 0, 8'd0, 0, 0);
    step(0, 0, 1, 1, 0, 8'd0, 0, 8'd0, 0, 0);
    for (int i = 1; i <= 255; i++) step(0, 1, 1, 1, 0, 8'd0, 0, 8'(i), 0, 0);
    step(0, 1, 1, 1, 0, 8'd0, 0, 8'd0, 1, 1);
    step(0, 1, 1, 1, 0, 8'd0, 0, 8'd1, 0, 1);
    // first enabled step after reset going down wraps to MOD_MAX
    step(0, 0, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0);
    step(0, 1, 1, 0, 0, 8'd0, 0, 8'd255, 1, 1);
    step(0, 1, 1, 0, 0, 8'd0, 0, 8'd254, 0, 1);

    // ---- dut_b: 4-bit, MOD_MAX=9, wrap ----
    step(1, 0, 0, 1, 0, 8'd0, 0, 8'd0, 0, 0);
    for (int i = 1; i <= 9; i++) step(1, 1, 1, 1, 0, 8'd0, 0, 8'(i), 0, 0);
    step(1, 1, 1, 1, 0, 8'd0, 0, 8'd0, 1, 1);
    step(1, 1, 1, 1, 0, 8'd0, 0, 8'd1, 0, 1);
    step(1, 1, 1, 1, 0, 8'd0, 0, 8'd2, 0, 1);
    step(1, 1, 1, 0, 0, 8'd0, 0, 8'd1, 0, 1);
    step(1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 0, 1);
    step(1, 1, 1, 0, 0, 8'd0, 0, 8'd9, 1, 1);
    step(1, 1, 1, 0, 0, 8'd0, 0, 8'd8, 0, 1);
    // clr_ovf on an idle edge clears; on a wrap edge set wins
    step(1, 1, 0, 0, 0, 8'd0, 1, 8'd8, 0, 0);
    step(1, 1, 0, 0, 1, 8'd9, 0, 8'd9, 0, 0);
    step(1, 1, 1, 1, 0, 8'd0, 1, 8'd0, 1, 1);
    // load beats en; ovf untouched by load
    step(1, 1, 1, 1, 1, 8'd5, 0, 8'd5, 0, 1);
    step(1, 1, 1, 1, 0, 8'd0, 0, 8'd6, 0, 1);
    // mid-count reset, then counting resumes at 1
    step(1, 0, 1, 1, 0, 8'd0, 0, 8'd0, 0, 0);
    step(1, 1, 1, 1, 0, 8'd0, 0, 8'd1, 0, 0);
    // out-of-range load clamps; reset beats load
    step(1, 1, 1, 0, 1, 8'd14, 0, 8'd9, 0, 0);
    step(1, 0, 0, 0, 1, 8'd5, 0, 8'd0, 0, 0);

    // ---- dut_c: 4-bit, MOD_MAX=9, saturate ----
    step(2, 0, 0, 1, 0, 8'd0, 0, 8'd0, 0, 0);
    step(2, 1, 0, 0, 1, 8'd7, 0, 8'd7, 0, 0);
    step(2, 1, 1, 1, 0, 8'd0, 0, 8'd8, 0, 0);
    step(2, 1, 1, 1, 0, 8'd0, 0, 8'd9, 0, 0);
    step(2, 1, 1, 1, 0, 8'd0, 0, 8'd9, 1, 1);
    step(2, 1, 1, 1, 0, 8'd0, 0, 8'd9, 1, 1);
    step(2, 1, 1, 0, 0, 8'd0, 0, 8'd8, 0, 1);
    for (int i = 7; i >= 0; i--) step(2, 1, 1, 0, 0, 8'd0, 0, 8'(i), 0, 1);
    step(2, 1, 1, 0, 0, 8'd0, 0, 8'd0, 1, 1);
    step(2, 1, 1, 1, 0, 8'd0, 0, 8'd1, 0, 1);
    step(2, 1, 0, 1, 0, 8'd0, 0, 8'd1, 0, 1);

    @(posedge clk);
    #1;
    en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    finishing = 1'b1;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
- Parametrised successor to the basic 8-bit free-running counter.
- Width and terminal value are configurable.
- Adds up/down direction, count enable and synchronous parallel load.
- Adds wrap or saturate mode, a registered terminal-count pulse and a sticky overflow flag.
- Used as the general-purpose counter/timer primitive across the design and in counter benches.

Parameters:
WIDTH, 8, bit width of the count value (min 2)
MOD_MAX, 255, terminal count value; legal range 1 .. 2**WIDTH-1; count range is 0..MOD_MAX
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block
en  input  1  count enable; one step per clock while high
up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value to load
clr_ovf  input  1  clears the sticky overflow flag
value  output  WIDTH  registered count
tc  output  1  registered one-cycle terminal-count pulse
ovf  output  1  sticky overflow/underflow flag, registered

Behaviour:
- Reset (reset=0 at a posedge):
  - value=0, tc=0, ovf=0.
  - Overrides every other input on that edge.
  - Asserting reset mid-count aborts the count with no tc pulse.
- Priority per edge: reset > load > en.
- Load (load=1):
  - value <= min(load_val, MOD_MAX); an out-of-range load clamps to MOD_MAX.
  - tc <= 0; ovf is unchanged, and en and up are ignored that cycle.
- Count (en=1, load=0), up=1:
  - value < MOD_MAX: value <= value+1.
  - value == MOD_MAX: boundary event. The next value is 0 if SATURATE=0, otherwise MOD_MAX (held).
- Count (en=1, load=0), up=0:
  - value > 0: value <= value-1.
  - value == 0: boundary event. The next value is MOD_MAX if SATURATE=0, otherwise 0 (held).
- Idle (en=0, load=0): value holds and tc <= 0.
- tc:
  - Registered alongside value; it is 1 for exactly the cycle in which value shows the post-boundary result, otherwise 0.
  - In saturate mode, each further enabled step held at the limit produces another boundary event, so tc stays high while en remains asserted at the limit.
- ovf:
  - Set on every boundary event, in both wrap and saturate mode.
  - Cleared by clr_ovf=1 when no boundary event occurs that edge.
  - A simultaneous boundary event and clr_ovf leaves ovf=1 (set wins).
  - Load does not affect ovf; reset clears it.
- Arithmetic:
  - Compare against MOD_MAX, never rely on natural WIDTH overflow. With MOD_MAX=2**WIDTH-1 the results must match.
  - No X propagation from load_val when load=0.
- Direction changes take effect immediately on the next enabled edge, with no dead cycle.
- Latency: value and tc change one clock after the sampling edge. There is no combinational path from any input to any output.
- After reset is released, the first enabled edge produces value=1 (up) or, when SATURATE=0, MOD_MAX (down).

Test Plan:
- WIDTH=8, MOD_MAX=255, SATURATE=0, up=1, en=1:
  - Hold reset=0 for 2 edges, then release.
  - Expect value 0 at release, then 1,2,...,255,0.
  - Expect tc=1 only in the cycle value=0 after 255, and ovf=1 thereafter.
- WIDTH=4, MOD_MAX=9, SATURATE=0:
  - Count up from 0: expect 0..9,0 with tc high one cycle at the wrap.
  - Switch up=0 at value=2: expect 1,0,9,8 with tc high when value=9.
- WIDTH=4, MOD_MAX=9, SATURATE=1, up=1, en=1 from 7:
  - Expect 8,9,9,9 with tc=1 on each held 9 and ovf=1.
  - Then up=0: expect 8, tc=0.
- Load checks:
  - load=1, load_val=5, en=1: next value=5, tc=0, no count that cycle.
  - load_val=14 with MOD_MAX=9: value=9.
  - load=1 coincident with reset=0: value=0.
- ovf clear race:
  - With ovf=1, assert clr_ovf at a non-boundary edge: ovf=0.
  - Assert clr_ovf on a wrap edge: ovf stays 1.
- Mid-count reset: at value=6 with en=1, pulse reset=0 for one edge. Expect value=0, tc=0, ovf=0 on that edge, and counting resumes at 1.
